// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the regfile write arbiter
package regfile_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int ZERO_REG       = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester bus and regfile write controls
interface regfile_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic                             freeze;
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_lock;
    logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
    logic [NUM_REQ-1:0]               req_ready;
    logic                             ctrl_writeEnable;
    logic [ADDR_WIDTH-1:0]            ctrl_writeReg;
    logic [DATA_WIDTH-1:0]            data_writeReg;
    logic [IDX_W-1:0]                 grant_id;
    logic                             locked;

    modport master (
        output freeze, req_valid, req_lock, req_addr, req_data,
        input  req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id, locked
    );

    modport slave (
        input  freeze, req_valid, req_lock, req_addr, req_data,
        output req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id, locked
    );

endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotate-priority picker: first set request at or after start
module rr_priority_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        logic found;
        int   j;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(start_i) + k) % N;
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin owner of the regfile write port with burst locking
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int LOCK_TIMEOUT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    arb_state_e             state_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  wreg_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [IDX_W-1:0]       gid_q;

    logic [NUM_REQ-1:0]     pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_REQ-1:0]     ready;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       next_ptr;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [DATA_WIDTH-1:0]  win_data;
    logic                   accept;

    rr_priority_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i   (bus.req_valid),
        .start_i (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // While locked only the owner can be granted; reset and freeze mask every grant.
    always_comb begin
        ready   = '0;
        win_idx = pick_idx;
        if (state_q == LOCKED) begin
            win_idx        = owner_q;
            ready[owner_q] = bus.req_valid[owner_q];
        end else begin
            ready = pick_grant;
        end
        if (!reset || bus.freeze) begin
            ready = '0;
        end
    end

    assign accept   = |ready;
    assign win_addr = bus.req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_data = bus.req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign next_ptr = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            gid_q    <= '0;
        end else if (bus.freeze) begin
            we_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (accept) begin
                we_q    <= (win_addr != ADDR_WIDTH'(ZERO_REG));
                wreg_q  <= win_addr;
                wdata_q <= win_data;
                gid_q   <= win_idx;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rr_ptr_q <= next_ptr;
                        if (bus.req_lock[win_idx]) begin
                            state_q <= LOCKED;
                            owner_q <= win_idx;
                            cnt_q   <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        if (bus.req_lock[win_idx]) begin
                            cnt_q <= '0;
                        end else begin
                            state_q  <= IDLE;
                            rr_ptr_q <= next_ptr;
                        end
                    end else begin
                        // Owner idle: count toward releasing the port, saturating at the limit.
                        if (cnt_q != CNT_W'(LOCK_TIMEOUT)) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= next_ptr;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready        = ready;
    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrl_writeReg    = wreg_q;
    assign bus.data_writeReg    = wdata_q;
    assign bus.grant_id         = gid_q;
    assign bus.locked           = (state_q == LOCKED);

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port between NUM_REQ writeback requesters, for example ALU writeback and multdiv/load writeback. Requesters are granted round-robin. A requester may lock the port for a burst of back-to-back writes. The grant is registered and drives the regfile write controls one cycle after the handshake. Writes to register 0 are accepted but never issued.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 32, write data width
ADDR_WIDTH, 5, register index width
LOCK_TIMEOUT, 4, idle cycles after which a lock owner loses its lock

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
freeze  in  1  when high, no grants are issued
req_valid  in  NUM_REQ  per-requester write request
req_lock  in  NUM_REQ  qualifies an accepted request: keep the port after this write
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  in  NUM_REQ*DATA_WIDTH  flattened, same packing
req_ready  out  NUM_REQ  one-hot or zero; grant for the current cycle (combinational)
ctrl_writeEnable  out  1  regfile write enable (registered)
ctrl_writeReg  out  ADDR_WIDTH  regfile write index (registered)
data_writeReg  out  DATA_WIDTH  regfile write data (registered)
grant_id  out  $clog2(NUM_REQ)  index of the requester behind the current write
locked  out  1  high while in LOCKED state

Behaviour:
- Reset (reset=0, asynchronous):
  - all registered outputs are 0; rr_ptr=0; state=IDLE; timeout counter=0.
  - req_ready is 0 while reset is low.
  - An in-flight write is discarded and is not replayed.
- Handshake:
  - Requester i is accepted in cycle t when req_valid[i] & req_ready[i].
  - Requesters hold addr and data stable until accepted.
  - At most one req_ready bit is high per cycle.
- freeze=1:
  - req_ready=0.
  - ctrl_writeEnable=0 on the following edge.
  - state, rr_ptr and the timeout counter hold their values.
- Latency: acceptance at edge t produces ctrl_writeEnable=1 with the accepted addr/data and grant_id=i during cycle t+1. Single-cycle pulse per accepted write.
- With no acceptance, ctrl_writeEnable=0 next cycle. ctrl_writeReg, data_writeReg and grant_id hold their last values.
- Register 0: the request is accepted (req_ready=1) but ctrl_writeEnable stays 0. grant_id still updates.
- IDLE state:
  - Winner is the first valid requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On acceptance of requester w, rr_ptr becomes (w+1) mod NUM_REQ.
  - If req_lock[w]=1 at acceptance, go to LOCKED with owner=w and the counter cleared.
- LOCKED state:
  - Only the owner can receive req_ready; other requesters are stalled.
  - Owner accepted with req_lock=1: stay in LOCKED, clear the counter.
  - Owner accepted with req_lock=0: go to IDLE; rr_ptr=(owner+1) mod NUM_REQ.
  - Owner req_valid=0: counter increments. When it reaches LOCK_TIMEOUT, go to IDLE on that edge; rr_ptr=(owner+1) mod NUM_REQ.
- Simultaneous events:
  - reset dominates freeze, and freeze dominates everything else.
  - A timeout and a new owner request cannot coincide, because the counter increments only when the owner is not valid.
- Counter width is $clog2(LOCK_TIMEOUT+1); the counter saturates and never wraps.
- No combinational path from req_* to the ctrl_* outputs.

Decomposition:
- Package regfile_pkg:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - Arbiter state enum {IDLE, LOCKED}.
  - ZERO_REG constant = 0.
- Sub-module rr_priority_pick: combinational rotate-priority picker. Inputs are a request vector and a start pointer; outputs are a one-hot grant and its index. The FSM, counter and output stage stay in the top module.

Test Plan:
1. reset=0 for 2 cycles, then release with no requests -> ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, grant_id=0, locked=0, req_ready=00.
2. req0 valid, addr 5, data 0xDEADBEEF -> req_ready=01 in cycle t; in cycle t+1 ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF, grant_id=0; in cycle t+2 ctrl_writeEnable=0.
3. Both valid every cycle, req0 addr 3 and req1 addr 4, fresh data each handshake -> grants alternate 0,1,0,1 from reset; the regfile sees writes 3,4,3,4 on consecutive cycles.
4. req1 addr 0, data 0x1234 -> req_ready=10, ctrl_writeEnable stays 0, grant_id=1 next cycle.
5. Lock scenario:
   - req1 sends 3 writes (addrs 7,8,9) with lock=1,1,0 while req0 is continuously valid -> three consecutive grants to 1, locked=1 during the burst; req0 is granted on the fourth cycle.
   - Repeat, but req1 drops valid after its first lock write -> req0 is granted after exactly 4 idle cycles (LOCK_TIMEOUT=4).
6. freeze=1 for 3 cycles with both valid -> req_ready=00 and no write pulses; state is held and arbitration resumes with the same rr_ptr.
   - Separately, assert reset mid-cycle during a write pulse -> ctrl_writeEnable drops to 0 immediately, without waiting for a clock edge.
